counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Run/pause/step/load controller for the lab's mod-N display counter. It conditions the four virtual buttons and paces the counter from `CLOCK_50` with a prescaler, so the counter no longer uses a button as its clock. It sequences the count through IDLE/RUN/PAUSE and drives one seven-segment digit plus status LEDs. The block is the top of the remote-lab counter exercise.

## Interface
- `MOD`, 8: counter modulus, legal 2..10; count range 0..MOD-1.
- `TICK_DIV`, 50_000_000: `CLOCK_50` cycles per RUN advance (1 Hz); legal ≥2.
- `DEB_CYCLES`, 500_000: stable-sample count for the debounce filter (10 ms); legal ≥1; used only with `SEQ_DEBOUNCE_EN`.

Ports:
- `CLOCK_50`  in  1  single clock for all logic.
- `SW[17]`  in  1  reset, asynchronous, active-high.
- `SW[16]`  in  1  direction: 0 = up, 1 = down; sampled at each advance.
- `SW[3:0]`  in  4  load value.
- `V_BT[3:0]`  in  4  active-high buttons, asynchronous to the clock: [0] start/pause, [1] step, [2] load, [3] clear.
- `HEX4[0:6]`  out  7  digit segments a..g, active-low.
- `LEDR[3:0]`  out  4  current count, binary.
- `LEDG[1:0]`  out  2  state code: IDLE=00, RUN=01, PAUSE=10.

## Operation
- Reset (`SW[17]`=1, any time, including mid-RUN):
  - count=0, state=IDLE, prescaler=0, synchronizer/debounce flops=0.
  - `HEX4`=0000001, `LEDR`=0000, `LEDG`=00.
- Button conditioning:
  - Each `V_BT` bit passes through a 2-flop synchronizer, then a rising-edge detector.
  - This produces a one-cycle press pulse per press; holding a button yields exactly one pulse.
- States:
  - IDLE: count held, ticks ignored. Start → RUN. Step → advance one.
  - RUN: prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and the count advances one. Start → PAUSE. Step ignored.
  - PAUSE: count held. Start → RUN. Step → advance one.
- Prescaler is cleared whenever the state is not RUN, so the first RUN advance occurs exactly TICK_DIV cycles after entering RUN.
- Advance direction:
  - Up: MOD-1 → 0.
  - Down: 0 → MOD-1.
- Load: count ← `SW[3:0]` if the value is < MOD, else MOD-1. State and prescaler are unchanged.
- Clear: count ← 0, state ← IDLE, prescaler ← 0.
- Same-cycle priority: clear > load > start/pause > step > tick. A lower-priority count update in the same cycle is dropped; start/pause still takes effect alongside load.
- Decode: 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100, other→1111111.

## Timing
- All state is registered on `CLOCK_50` rising edge; reset is the only asynchronous input.
- Button-to-action latency, without debounce: `V_BT` high before edge 1 → count/state updated at edge 3.
- With `SEQ_DEBOUNCE_EN`, add DEB_CYCLES edges to that latency.
- `HEX4`, `LEDR` and `LEDG` are combinational from registered count/state, so they change in the same cycle as the count.
- Direction is sampled in the advance cycle; a toggle mid-RUN affects the next advance only.

## Configuration
- `SEQ_DEBOUNCE_EN` defined:
  - Each synchronized button feeds a counter filter.
  - The filtered level changes only after DEB_CYCLES consecutive equal samples.
  - The edge detector runs on the filtered level, so bounces shorter than DEB_CYCLES produce no pulse.
- `SEQ_DEBOUNCE_EN` undefined: the edge detector runs directly on the synchronizer output; DEB_CYCLES is unused.

## Structure
- Shared package `counter_seq_pkg`:
  - State encodings (IDLE/RUN/PAUSE).
  - Button index constants (START=0, STEP=1, LOAD=2, CLEAR=3).
  - Seven-segment pattern constants and blank pattern.
- Sub-module `btn_cond`: synchronizer, optional debounce and edge detect for one bit. Instantiated four times.
- Top holds the FSM, prescaler, counter and decoder.

## Test plan
- Reset then no input: `HEX4`=0000001, `LEDG`=00 indefinitely. Reset asserted mid-RUN at count 5 → immediately count 0, IDLE.
- TICK_DIV=4, up, start pulse: count 0→1→2… every 4 cycles. At 7 the next advance → 0 (MOD=8). `HEX4`=0001111 at count 7.
- PAUSE at count 3, SW[16]=1, step ×4: counts 2, 1, 0, 7. Step pressed during RUN: no change.
- Load SW[3:0]=9 with MOD=8: count=7. Load=4: count=4. Load and tick in the same cycle: count=4.
- Clear and step pressed in the same cycle from PAUSE at count 6: count=0, state IDLE.
- With `SEQ_DEBOUNCE_EN`, DEB_CYCLES=3: a 2-cycle glitch on `V_BT[1]` → no step. A 10-cycle press → exactly one step, at edge 6 after the rise.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter_sequencer slice: state codes,
// button indices, seven-segment patterns and the count advance helper.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam int BTN_START = 0;
  localparam int BTN_STEP  = 1;
  localparam int BTN_LOAD  = 2;
  localparam int BTN_CLEAR = 3;

  // Segment order a..g, active-low.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    state_t     state;
    logic [3:0] count;
    logic       tick;
  } seq_dbg_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    case (value)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // One step of a mod-(max+1) counter in either direction, wrapping at the ends.
  function automatic logic [3:0] advance(input logic [3:0] value,
                                         input logic       down,
                                         input logic [3:0] max);
    if (down) advance = (value == 4'd0) ? max : value - 4'd1;
    else      advance = (value == max)  ? 4'd0 : value + 4'd1;
  endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Board-side signal bundle of the counter_sequencer: switches, virtual
// buttons, display outputs and a debug view of the sequencer state.
interface counter_sequencer_if;
  import counter_seq_pkg::*;

  // All signals are plain levels; there is no valid/ready handshake. Buttons
  // are asynchronous and are conditioned inside the block.
  logic [17:0] SW;
  logic [3:0]  V_BT;
  logic [0:6]  HEX4;
  logic [3:0]  LEDR;
  logic [1:0]  LEDG;
  seq_dbg_t    dbg;

  modport master (output SW, V_BT, input HEX4, LEDR, LEDG, dbg);
  modport slave  (input SW, V_BT, output HEX4, LEDR, LEDG, dbg);
endinterface

// File: rtl/counter_sequencer_btn_cond.sv
// btn_cond: 2-flop synchronizer, optional counter debounce (SEQ_DEBOUNCE_EN)
// and rising-edge detector producing a one-cycle press pulse for one button.
module btn_cond #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic [1:0] sync_q;
  logic       level;
  logic       level_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], btn};
  end

`ifdef SEQ_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt_q;
  logic          deb_level_q;

  // The filtered level flips on the DEB_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q   <= '0;
      deb_level_q <= 1'b0;
    end else if (sync_q[1] == deb_level_q) begin
      deb_cnt_q   <= '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_cnt_q   <= '0;
      deb_level_q <= sync_q[1];
    end else begin
      deb_cnt_q   <= deb_cnt_q + 1'b1;
    end
  end

  assign level = deb_level_q;
`else
  localparam bit unused_deb_cycles = (DEB_CYCLES > 0);
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_prev_q <= 1'b0;
    else     level_prev_q <= level;
  end

  assign press = level & ~level_prev_q;

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: run/pause/step/load controller for the mod-N display
// counter. Define SEQ_DEBOUNCE_EN to add the counter debounce on each button.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int MOD        = 8,
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input logic                CLOCK_50,
  counter_sequencer_if.slave io
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]    COUNT_MAX = 4'(MOD - 1);

  logic          rst;
  logic [3:0]    press;
  logic          unused_sw;

  state_t        state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [3:0]    load_value;

  assign rst       = io.SW[17];
  assign unused_sw = ^io.SW[15:4];

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk   (CLOCK_50),
      .rst   (rst),
      .btn   (io.V_BT[i]),
      .press (press[i])
    );
  end

  // Out-of-range load values saturate to the top of the count range.
  assign load_value = (io.SW[3:0] > COUNT_MAX) ? COUNT_MAX : io.SW[3:0];

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= 4'd0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tick    = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    presc_d = '0;
    if (state_q == ST_RUN) presc_d = tick ? '0 : presc_q + 1'b1;

    if (press[BTN_CLEAR]) begin
      state_d = ST_IDLE;
      count_d = 4'd0;
      presc_d = '0;
    end else begin
      if (press[BTN_START]) begin
        case (state_q)
          ST_IDLE, ST_PAUSE: state_d = ST_RUN;
          ST_RUN:            state_d = ST_PAUSE;
          default:           state_d = ST_IDLE;
        endcase
      end
      // Only one count update per cycle: load, then step, then tick.
      if (press[BTN_LOAD]) begin
        count_d = load_value;
      end else if (!press[BTN_START]) begin
        if (press[BTN_STEP] && (state_q != ST_RUN)) count_d = advance(count_q, io.SW[16], COUNT_MAX);
        else if (tick)                               count_d = advance(count_q, io.SW[16], COUNT_MAX);
      end
    end
  end

  always_comb begin
    io.LEDG      = state_q;
    io.LEDR      = count_q;
    io.HEX4      = seg_decode(count_q);
    io.dbg.state = state_q;
    io.dbg.count = count_q;
    io.dbg.tick  = tick;
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with MOD=8, TICK_DIV=4, DEB_CYCLES=3;
// the glitch/long-press checks apply when SEQ_DEBOUNCE_EN is defined.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int MOD        = 8;
  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 3;
`ifdef SEQ_DEBOUNCE_EN
  localparam int LAT = 3 + DEB_CYCLES;
  localparam int GAP = DEB_CYCLES + 3;
`else
  localparam int LAT = 3;
  localparam int GAP = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  counter_sequencer_if io ();

  counter_sequencer #(
    .MOD        (MOD),
    .TICK_DIV   (TICK_DIV),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .CLOCK_50 (clk),
    .io       (io.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int v);
    case (v)
      0: seg_ref = 7'b0000001;
      1: seg_ref = 7'b1001111;
      2: seg_ref = 7'b0010010;
      3: seg_ref = 7'b0000110;
      4: seg_ref = 7'b1001100;
      5: seg_ref = 7'b0100100;
      6: seg_ref = 7'b0100000;
      7: seg_ref = 7'b0001111;
      8: seg_ref = 7'b0000000;
      9: seg_ref = 7'b0000100;
      default: seg_ref = 7'b1111111;
    endcase
  endfunction

  function automatic int dn(input int c);
    return (c == 0) ? MOD - 1 : c - 1;
  endfunction

  task automatic check_out(input string tag, input int cnt, input int st);
    check({tag, "_count"}, 32'(io.LEDR), 32'(cnt));
    check({tag, "_state"}, 32'(io.LEDG), 32'(st));
    check({tag, "_hex"},   32'(io.HEX4), 32'(seg_ref(cnt)));
  endtask

  // driver tasks
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge following the edge on which the press acts.
  task automatic press_btn(input logic [3:0] mask);
    io.V_BT = mask;
    wait_n(LAT);
    io.V_BT = 4'b0000;
  endtask

  task automatic gap();
    wait_n(GAP);
  endtask

  initial begin
    int e;
    int c;
    io.SW   = 18'd0;
    io.V_BT = 4'b0000;
    io.SW[17] = 1'b1;
    wait_n(2);
    check_out("reset", 0, 0);
    io.SW[17] = 1'b0;
    wait_n(20);
    check_out("idle_hold", 0, 0);

    press_btn(4'b0010);
    check_out("idle_step_up", 1, 0);
    gap();
    press_btn(4'b1000);
    check_out("clear_idle", 0, 0);
    gap();

    // RUN, counting up every TICK_DIV cycles with wrap
    press_btn(4'b0001);
    check_out("run_enter", 0, 1);
    wait_n(TICK_DIV - 1);
    check("run_no_early", 32'(io.LEDR), 32'd0);
    for (int i = 1; i < MOD; i++) exp_q.push_back(32'(i));
    exp_q.push_back(32'd0);
    wait_n(1);
    while (exp_q.size() > 0) begin
      e = int'(exp_q.pop_front());
      check("run_adv", 32'(io.LEDR), 32'(e));
      if (e == 7) check("run_hex7", 32'(io.HEX4), 32'(7'b0001111));
      if (exp_q.size() > 0) wait_n(TICK_DIV);
    end
    wait_n(3 * TICK_DIV);
    check("run_at3", 32'(io.LEDR), 32'd3);

    press_btn(4'b0001);
    c = (3 + (LAT - 1) / TICK_DIV) % MOD;
    check_out("pause", c, 2);
    gap();

    // down steps in PAUSE: 3 -> 2, 1, 0, 7
    io.SW[16] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      press_btn(4'b0010);
      c = dn(c);
      check_out("pause_step_down", c, 2);
      gap();
    end

    // step ignored in RUN; ticks count down
    press_btn(4'b0001);
    check_out("resume", c, 1);
    press_btn(4'b0010);
    e = c;
    repeat (LAT / TICK_DIV) e = dn(e);
    check("run_step_ignored", 32'(io.LEDR), 32'(e));
    wait_n(2 * TICK_DIV - LAT);
    c = dn(dn(c));
    check("run_down", 32'(io.LEDR), 32'(c));

    press_btn(4'b0001);
    repeat ((LAT - 1) / TICK_DIV) c = dn(c);
    check_out("pause2", c, 2);
    gap();

    io.SW[3:0] = 4'd9;
    press_btn(4'b0100);
    check_out("load_clamp", 7, 2);
    gap();
    io.SW[3:0] = 4'd4;
    press_btn(4'b0100);
    check_out("load_4", 4, 2);
    gap();

    // load lands on the same edge as a tick: load wins
    io.SW[3:0] = 4'd5;
    press_btn(4'b0001);
    check_out("run_load", 4, 1);
    wait_n((TICK_DIV - (LAT % TICK_DIV)) % TICK_DIV);
    press_btn(4'b0100);
    check_out("load_tick", 5, 1);

    press_btn(4'b0001);
    c = 5;
    repeat ((LAT - 1) / TICK_DIV) c = dn(c);
    check_out("pause3", c, 2);
    gap();
    io.SW[3:0] = 4'd6;
    press_btn(4'b0100);
    check_out("load_6", 6, 2);
    gap();

    press_btn(4'b1010);
    check_out("clear_step", 0, 0);
    gap();

    // asynchronous reset mid-RUN at count 5
    io.SW[16]  = 1'b0;
    io.SW[3:0] = 4'd5;
    press_btn(4'b0100);
    gap();
    press_btn(4'b0001);
    wait_n(2);
    check_out("run_at5", 5, 1);
    io.SW[17] = 1'b1;
    #1;
    check_out("reset_mid_run", 0, 0);
    @(negedge clk);
    io.SW[17] = 1'b0;
    wait_n(3 * TICK_DIV);
    check_out("post_reset", 0, 0);

`ifdef SEQ_DEBOUNCE_EN
    io.V_BT[1] = 1'b1;
    wait_n(2);
    io.V_BT[1] = 1'b0;
    wait_n(12);
    check("deb_glitch", 32'(io.LEDR), 32'd0);
    io.V_BT[1] = 1'b1;
    wait_n(5);
    check("deb_before_edge6", 32'(io.LEDR), 32'd0);
    wait_n(1);
    check("deb_edge6", 32'(io.LEDR), 32'd1);
    wait_n(4);
    io.V_BT[1] = 1'b0;
    wait_n(12);
    check("deb_once", 32'(io.LEDR), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
